// File: rtl/hazard_sequencer.sv
// Issue/stall sequencer for the 4-stage MIPS pipeline (IF, ID, EX, MEM/WB).
// Holds instructions at ID on read-after-write hazards using a per-register
// countdown scoreboard, freezes fetch while a control transfer is unresolved,
// and honours an external whole-pipeline hold.
//
// Handshake/timing contract: every input is sampled in the cycle it is
// presented; pc_en, ifid_en, ifid_flush, idex_flush and pipe_en are valid in
// that same cycle and take effect at the next rising edge. resolve_valid is a
// single-cycle pulse; a pulse that lands during a hold is remembered and
// applied when the hold ends.
module hazard_sequencer #(
    parameter int WB_LATENCY = 3,  // issue-to-dependent-issue distance, 1..7
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_reg_write,
    input  logic [4:0]       id_write_reg,
    input  logic             id_is_ctrl,
    input  logic             resolve_valid,
    input  logic             hold_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] ctrl_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CTRL_WAIT = 2'd1,
        HOLD      = 2'd2
    } seqState_t;

    // A load of WB_LATENCY-1 followed by one decrement per cycle lets the
    // consumer issue exactly WB_LATENCY cycles after the producer.
    localparam logic [2:0] LOAD_VAL = 3'(WB_LATENCY - 1);

    seqState_t  curState;
    seqState_t  savedState;
    logic       pendingResolve;
    logic [2:0] sb [32];  // entry 0 is never loaded and so always reads 0

    logic rsBusy;
    logic rtBusy;
    logic hazard;
    logic issue;
    logic recordWrite;
    logic resolveEff;

    assign state = curState;

    // Hazard detection and issue qualification for the instruction in ID.
    always_comb begin
        rsBusy      = id_use_rs && (sb[id_rs] != 3'd0);
        rtBusy      = id_use_rt && (sb[id_rt] != 3'd0);
        hazard      = id_valid && (rsBusy || rtBusy);
        issue       = (curState == RUN) && id_valid && !hazard && !hold_req;
        recordWrite = issue && id_reg_write && (id_write_reg != 5'd0);
        resolveEff  = resolve_valid || pendingResolve;
    end

    // Pipeline enables and flushes; they must react within the same cycle,
    // so they are decoded from the registered state plus current inputs.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_en    = 1'b1;
        if (!reset) begin
            // free-running defaults while reset is held
        end else if (hold_req || (curState == HOLD)) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            pipe_en = 1'b0;
        end else if (curState == CTRL_WAIT) begin
            pc_en      = resolveEff;
            ifid_flush = 1'b1;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (issue && id_is_ctrl) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    // Sequencer FSM with hold save/restore, latched resolve and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState       <= RUN;
            savedState     <= RUN;
            pendingResolve <= 1'b0;
            stall_cnt      <= '0;
            ctrl_cnt       <= '0;
        end else if (hold_req) begin
            if (curState != HOLD) begin
                savedState <= curState;
                curState   <= HOLD;
            end
            if (resolve_valid) begin
                pendingResolve <= 1'b1;
            end
        end else begin
            case (curState)
                HOLD: begin
                    curState <= savedState;
                    // a remembered resolve only means something to CTRL_WAIT
                    if (savedState != CTRL_WAIT) begin
                        pendingResolve <= 1'b0;
                    end
                end
                CTRL_WAIT: begin
                    if (ctrl_cnt != '1) begin
                        ctrl_cnt <= ctrl_cnt + CNT_W'(1);
                    end
                    if (resolveEff) begin
                        curState       <= RUN;
                        pendingResolve <= 1'b0;
                    end
                end
                RUN: begin
                    if (hazard) begin
                        if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + CNT_W'(1);
                        end
                    end else if (issue && id_is_ctrl) begin
                        curState <= CTRL_WAIT;
                    end
                end
                default: begin
                    curState <= RUN;
                end
            endcase
        end
    end

    // Pending-write scoreboard: load on issue, count down otherwise, freeze on hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                sb[i] <= 3'd0;
            end
        end else if (!hold_req) begin
            for (int i = 1; i < 32; i++) begin
                if (recordWrite && (id_write_reg == 5'(i))) begin
                    sb[i] <= LOAD_VAL;
                end else if (sb[i] != 3'd0) begin
                    sb[i] <= sb[i] - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model that tracks, per
// register, the un-held cycle number from which it becomes readable.
module tb_hazard_sequencer;

    localparam int WB   = 3;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          id_valid, id_use_rs, id_use_rt, id_reg_write, id_is_ctrl;
    logic [4:0]    id_rs, id_rt, id_write_reg;
    logic          resolve_valid, hold_req;
    logic          pc_en, ifid_en, ifid_flush, idex_flush, pipe_en;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, ctrl_cnt;

    hazard_sequencer #(.WB_LATENCY(WB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_reg_write(id_reg_write), .id_write_reg(id_write_reg),
        .id_is_ctrl(id_is_ctrl), .resolve_valid(resolve_valid), .hold_req(hold_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_en(pipe_en), .state(state),
        .stall_cnt(stall_cnt), .ctrl_cnt(ctrl_cnt)
    );

    // ---------------- scoreboard / reference model ----------------
    int testsRun    = 0;
    int testsFailed = 0;
    logic [4:0] exp_q[$];   // expected {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en}

    int tick;               // number of hold-free cycles since reset
    int readyTick [32];     // first tick at which a register may be read
    int mMode;              // 0 run, 1 waiting for resolve, 2 held
    int mSaved;
    bit mPend;
    int mStall, mCtrl;

    logic [4:0] obsCtrl;
    logic [1:0] obsState;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit modelHazard();
        bit rsWait, rtWait;
        rsWait = id_use_rs && (id_rs != 5'd0) && (readyTick[id_rs] > tick);
        rtWait = id_use_rt && (id_rt != 5'd0) && (readyTick[id_rt] > tick);
        return id_valid && (rsWait || rtWait);
    endfunction

    function automatic logic [4:0] expectedCtrl();
        if (hold_req || mMode == 2) return 5'b00000;
        if (mMode == 1) return {resolve_valid || mPend, 4'b1101};
        if (modelHazard()) return 5'b00011;
        if (id_valid && id_is_ctrl) return 5'b01101;
        return 5'b11001;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic modelClear();
        tick = 0;
        for (int i = 0; i < 32; i++) readyTick[i] = 0;
        mMode = 0; mSaved = 0; mPend = 0; mStall = 0; mCtrl = 0;
        exp_q.delete();
    endtask

    // Apply one clock edge's worth of behaviour using the current inputs.
    task automatic modelAdvance();
        bit haz;
        haz = modelHazard();
        if (hold_req) begin
            if (mMode != 2) begin
                mSaved = mMode;
                mMode  = 2;
            end
            if (resolve_valid) mPend = 1;
        end else begin
            if (mMode == 2) begin
                mMode = mSaved;
                if (mSaved != 1) mPend = 0;
            end else if (mMode == 1) begin
                mCtrl = sat(mCtrl + 1);
                if (resolve_valid || mPend) begin
                    mMode = 0;
                    mPend = 0;
                end
            end else if (haz) begin
                mStall = sat(mStall + 1);
            end else if (id_valid) begin
                if (id_reg_write && id_write_reg != 5'd0) readyTick[id_write_reg] = tick + WB;
                if (id_is_ctrl) mMode = 1;
            end
            tick++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic setInputs(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                             input bit urs, input bit urt, input bit rw, input logic [4:0] wr,
                             input bit ctrl, input bit res, input bit hold);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_reg_write = rw; id_write_reg = wr; id_is_ctrl = ctrl;
        resolve_valid = res; hold_req = hold;
    endtask

    task automatic step(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt, input bit rw, input logic [4:0] wr,
                        input bit ctrl, input bit res, input bit hold);
        @(negedge clk);
        setInputs(v, rs, rt, urs, urt, rw, wr, ctrl, res, hold);
        #1;
        obsCtrl  = {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en};
        obsState = state;
        exp_q.push_back(expectedCtrl());
        checkVal("ctrl_outs", obsCtrl, exp_q.pop_front());
        checkVal("state", obsState, mMode);
        checkVal("stall_cnt", stall_cnt, mStall);
        checkVal("ctrl_cnt", ctrl_cnt, mCtrl);
        modelAdvance();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset asynchronously mid-cycle, check the immediate clear, release.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkVal("rst_state", state, 0);
        checkVal("rst_stall_cnt", stall_cnt, 0);
        checkVal("rst_ctrl_cnt", ctrl_cnt, 0);
        checkVal("rst_outs", {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en}, 5'b11001);
        modelClear();
        @(negedge clk);
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        modelAdvance();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelClear();
        repeat (2) @(posedge clk);
        doReset();

        // RAW on $8 with latency 3: two stall cycles, then issue.
        idle();
        step(1, 0, 0, 1, 0, 1, 8, 0, 0, 0);
        step(1, 8, 8, 1, 1, 1, 9, 0, 0, 0);
        checkVal("raw_stall1_pc", obsCtrl[4], 0);
        checkVal("raw_stall1_idex_flush", obsCtrl[1], 1);
        step(1, 8, 8, 1, 1, 1, 9, 0, 0, 0);
        checkVal("raw_stall2_pc", obsCtrl[4], 0);
        step(1, 8, 8, 1, 1, 1, 9, 0, 0, 0);
        checkVal("raw_issue_pc", obsCtrl[4], 1);
        idle();
        checkVal("raw_stall_total", stall_cnt, 2);

        // Writes to $0 never create a hazard.
        doReset();
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 4, 0, 0, 0);
        checkVal("zero_reg_pc", obsCtrl[4], 1);
        idle();
        checkVal("zero_reg_stall", stall_cnt, 0);

        // Branch issue, resolved two cycles later.
        doReset();
        step(1, 1, 2, 0, 0, 0, 0, 1, 0, 0);
        checkVal("beq_issue_outs", obsCtrl, 5'b01101);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("beq_wait_outs", obsCtrl, 5'b01101);
        checkVal("beq_wait_state", obsState, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkVal("beq_resolve_outs", obsCtrl, 5'b11101);
        idle();
        checkVal("beq_back_to_run", obsState, 0);
        checkVal("beq_ctrl_cnt", ctrl_cnt, 2);

        // Hold during CTRL_WAIT with a resolve inside the hold window.
        doReset();
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkVal("hold1_outs", obsCtrl, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkVal("hold2_outs", obsCtrl, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkVal("hold4_state", obsState, 2);
        idle();
        checkVal("hold_exit_outs", obsCtrl, 0);
        idle();
        checkVal("hold_latched_state", obsState, 1);
        checkVal("hold_latched_pc", obsCtrl[4], 1);
        idle();
        checkVal("hold_after_state", obsState, 0);

        // Back-to-back writes to $5 push the consumer out to cycle 5.
        doReset();
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        checkVal("b2b_c3_pc", obsCtrl[4], 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        checkVal("b2b_c4_pc", obsCtrl[4], 0);
        step(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        checkVal("b2b_c5_pc", obsCtrl[4], 1);

        // Reset in CTRL_WAIT with $7 pending clears everything.
        doReset();
        step(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        idle();
        checkVal("rst_mid_state_before", obsState, 1);
        doReset();
        step(1, 7, 7, 1, 1, 0, 0, 0, 0, 0);
        checkVal("rst_mid_no_stall", obsCtrl[4], 1);

        // Randomized traffic on a small register window to force hazards.
        begin
            int holdLeft;
            holdLeft = 0;
            for (int n = 0; n < 3000; n++) begin
                bit hold;
                if (n % 700 == 699) doReset();
                if (holdLeft > 0) begin
                    hold = 1;
                    holdLeft--;
                end else if ($urandom_range(0, 19) == 0) begin
                    hold = 1;
                    holdLeft = $urandom_range(0, 3);
                end else begin
                    hold = 0;
                end
                step($urandom_range(0, 9) != 0,
                     5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, hold);
            end
        end

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
